// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, widths and slot decode helper for the APB bridge
//
// Purpose : bridge FSM state encoding, default bus widths, slot-field position
//           and the slot legality check shared with the interconnect decoder.
// Ports   : none (package).

package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 32;
  localparam int NUM_SLAVES_DEF = 6;
  localparam int TIMEOUT_DEF    = 16;

  // Slot field is the top nibble of the address (addr[11:8] for a 12-bit bus).
  localparam int SLOT_W   = 4;
  localparam int SLOT_MSB = ADDR_W_DEF - 1;
  localparam int SLOT_LSB = ADDR_W_DEF - SLOT_W;

  // A slot is legal when it indexes one of the attached slaves.
  function automatic logic slot_legal(input logic [SLOT_W-1:0] slot,
                                      input int unsigned        num_slaves);
    return (int'(slot) < int'(num_slaves));
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS-phase wait-state counter with timeout detect
//
// Purpose : counts ACCESS cycles spent waiting for pready. Saturates instead of
//           wrapping. expired is high while the count sits at TIMEOUT-1, i.e.
//           during the TIMEOUT-th waiting ACCESS cycle. TIMEOUT=0 disables it.
// Ports   :
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  reset count to zero (synchronous)
//   inc      in  advance count by one (saturating)
//   expired  out count has reached TIMEOUT-1 (never set when TIMEOUT=0)

module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;
  localparam logic [W-1:0] MAX  = {W{1'b1}};

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat host request to APB master bridge
//
// Purpose : accepts one valid/ready host request at a time, runs an APB
//           SETUP/ACCESS transfer (or rejects an illegal slot locally), handles
//           wait states with a pready timeout and returns a one-cycle response.
// Ports   :
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              host request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata     request fields
//   resp_valid/resp_rdata/resp_err   one-cycle response pulse, no backpressure
//   paddr/pwrite/pwdata/psel/penable APB master outputs (all registered)
//   pready/prdata/pslverr            APB completion from selected slave

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_SLAVES = NUM_SLAVES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  state_t state;
  logic   timer_clear;
  logic   timer_inc;
  logic   timer_expired;
  logic   req_slot_ok;

  assign req_ready   = (state == ST_IDLE);
  assign req_slot_ok = slot_legal(req_addr[ADDR_W-1 -: SLOT_W], NUM_SLAVES);

  // Timer restarts on the way into ACCESS and counts only cycles where the
  // slave is stalling.
  assign timer_clear = (state == ST_SETUP);
  assign timer_inc   = (state == ST_ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      // Response is a single-cycle pulse; defaults keep it low otherwise.
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            // Address phase is latched even for an illegal slot so paddr
            // reflects the last request; psel only rises for legal slots.
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_wdata;
            if (req_slot_ok) begin
              psel  <= 1'b1;
              state <= ST_SETUP;
            end else begin
              state <= ST_ERR;
            end
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= pslverr;
            resp_rdata <= (pwrite || pslverr) ? '0 : prdata;
            state      <= ST_IDLE;
          end else if (timer_expired) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        ST_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge

module tb_apb_master_bridge;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 6;
  localparam int TIMEOUT    = 16;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_bridge #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SLAVES (NUM_SLAVES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .psel       (psel),
    .penable    (penable),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One host transaction. The expected response is derived from the request
  // and the slave behaviour: illegal slot -> error at cycle 2; slave stalling
  // for TIMEOUT or more ACCESS cycles -> timeout error at cycle 2+TIMEOUT;
  // otherwise response at cycle 3+wait_n carrying pslverr and read data.
  task automatic do_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input int wait_n, input logic serr, input logic [31:0] rd);
    logic        legal, tmo, exp_err;
    int          exp_lat, acc, psel_cnt, addr_bad, lat;
    logic [31:0] exp_rd;
    bit          got;
    legal    = (int'(addr[11:8]) < NUM_SLAVES);
    tmo      = legal && (TIMEOUT != 0) && (wait_n >= TIMEOUT);
    exp_lat  = !legal ? 2 : (tmo ? 2 + TIMEOUT : 3 + wait_n);
    exp_err  = !legal || tmo || serr;
    exp_rd   = (wr || exp_err) ? 32'h0 : rd;
    acc      = 0;
    psel_cnt = 0;
    addr_bad = 0;
    lat      = 0;
    got      = 1'b0;

    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = $urandom;
    req_addr  = ADDR_W'($urandom);
    req_wdata = $urandom;

    for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("setup_psel", {31'b0, psel}, {31'b0, legal});
        chk("setup_penable", {31'b0, penable}, 32'd0);
      end
      if (cyc == 2 && legal) chk("access_penable", {31'b0, penable}, 32'd1);
      if (psel) begin
        psel_cnt++;
        if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wd)) addr_bad++;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = cyc;
        chk("resp_latency", lat, exp_lat);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_psel_low", {31'b0, psel}, 32'd0);
        chk("resp_req_ready", {31'b0, req_ready}, 32'd1);
      end
      // Slave model: completes on the wait_n-th ACCESS cycle; noise elsewhere
      // must be ignored by the bridge.
      if (psel && penable) begin
        if (acc == wait_n) begin
          pready  = 1'b1;
          pslverr = serr;
          prdata  = rd;
        end else begin
          pready  = 1'b0;
          pslverr = $urandom;
          prdata  = $urandom;
        end
        acc++;
      end else begin
        pready  = $urandom;
        pslverr = $urandom;
        prdata  = $urandom;
      end
    end

    chk("resp_seen", {31'b0, got}, 32'd1);
    chk("addr_stable", addr_bad, 0);
    if (!legal) chk("illegal_no_psel", psel_cnt, 0);
    if (tmo) chk("timeout_psel_cycles", psel_cnt, 1 + TIMEOUT);
    @(negedge clk);
    chk("resp_pulse_one_cycle", {31'b0, resp_valid}, 32'd0);
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_paddr", {20'b0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Directed scenarios
    do_txn(1'b1, 12'h000, 32'd4,  0,  1'b0, 32'h0);
    do_txn(1'b0, 12'h300, 32'h0,  3,  1'b0, 32'hD);
    do_txn(1'b1, 12'h400, 32'd18, 0,  1'b1, 32'h0);
    do_txn(1'b0, 12'h500, 32'h0,  99, 1'b0, 32'h55);
    do_txn(1'b0, 12'h700, 32'h0,  0,  1'b0, 32'h77);
    do_txn(1'b0, 12'h5FF, 32'h0,  15, 1'b0, 32'hCAFE);

    // Reset during ACCESS: bus drops immediately, no response appears.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 12'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pready    = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_penable", {31'b0, penable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel", {31'b0, psel}, 32'd0);
    chk("async_rst_penable", {31'b0, penable}, 32'd0);
    chk("async_rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_no_resp", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    do_txn(1'b0, 12'h210, 32'h0, 1, 1'b0, 32'h1234_5678);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      logic        wr;
      logic [11:0] addr;
      int          r;
      int          wn;
      wr   = $urandom;
      addr = {4'($urandom_range(0, 7)), 8'($urandom)};
      r    = $urandom_range(0, 7);
      wn   = (r == 7) ? 20 : r;
      do_txn(wr, addr, $urandom, wn, 1'($urandom_range(0, 3) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
